// File: rtl/d_latch.sv
// Clock-synchronous emulation of a transparent D latch with enable.
// d/en share one synchronizer depth so their pin alignment survives; en_s then gates a hold register.
module d_latch #(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             transparent
);

    logic [WIDTH-1:0] d_s;
    logic             en_s;

    if (SYNC_STAGES == 0) begin : g_bypass
        assign d_s  = d;
        assign en_s = en;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][WIDTH-1:0] d_sync_q, d_sync_d;
        logic [SYNC_STAGES-1:0]            en_sync_q, en_sync_d;

        // Reset clears every stage so a stale en=1 can never reopen the latch after reset.
        always_comb begin
            d_sync_d  = '0;
            en_sync_d = '0;
            if (!rst) begin
                d_sync_d[0]  = d;
                en_sync_d[0] = en;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    d_sync_d[i]  = d_sync_q[i-1];
                    en_sync_d[i] = en_sync_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            d_sync_q  <= d_sync_d;
            en_sync_q <= en_sync_d;
        end

        assign d_s  = d_sync_q[SYNC_STAGES-1];
        assign en_s = en_sync_q[SYNC_STAGES-1];
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             transparent_q, transparent_d;

    always_comb begin
        q_d           = q_q;
        transparent_d = 1'b0;
        if (rst) begin
            q_d = RESET_VALUE;
        end else if (en_s) begin
            q_d           = d_s;
            transparent_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        q_q           <= q_d;
        transparent_q <= transparent_d;
    end

    assign q           = q_q;
    assign transparent = transparent_q;

endmodule

// File: tb/tb_d_latch.sv
// Bench for d_latch: default instance (WIDTH=1, SYNC_STAGES=2) and a bypass instance
// (WIDTH=8, SYNC_STAGES=0, RESET_VALUE=8'hA5), both checked every cycle against a history-based model.
module tb_d_latch;

    localparam int NMAX = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, d0, en0, q0, tr0;
    logic       rst1, en1, tr1;
    logic [7:0] d1, q1;

    d_latch u_dut0 (
        .clk        (clk),
        .rst        (rst0),
        .d          (d0),
        .en         (en0),
        .q          (q0),
        .transparent(tr0)
    );

    d_latch #(
        .WIDTH      (8),
        .SYNC_STAGES(0),
        .RESET_VALUE(8'hA5)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst1),
        .d          (d1),
        .en         (en1),
        .q          (q1),
        .transparent(tr1)
    );

    // Pin values as seen at each rising edge, per channel.
    bit         rst_h[2][NMAX];
    bit         en_h [2][NMAX];
    logic [7:0] d_h  [2][NMAX];
    int         cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) begin
        if (cyc < NMAX) begin
            rst_h[0][cyc] <= rst0;
            en_h[0][cyc]  <= en0;
            d_h[0][cyc]   <= {7'b0, d0};
            rst_h[1][cyc] <= rst1;
            en_h[1][cyc]  <= en1;
            d_h[1][cyc]   <= d1;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    // Edge u captures when the pin en seen s edges earlier was 1 and no reset hit it in transit.
    function automatic bit cap(input int ch, input int u, input int s);
        if (u < s || rst_h[ch][u]) return 1'b0;
        for (int k = u - s; k < u; k++) begin
            if (rst_h[ch][k]) return 1'b0;
        end
        return en_h[ch][u-s];
    endfunction

    // q after edge t is set by the most recent reset or capture at or before t.
    function automatic void model(input int ch, input int t, input int s, input logic [7:0] rv,
                                  output bit known, output logic [7:0] mq);
        known = 1'b0;
        mq    = rv;
        for (int u = t; u >= 0 && !known; u--) begin
            if (rst_h[ch][u]) begin
                known = 1'b1;
                mq    = rv;
            end else if (cap(ch, u, s)) begin
                known = 1'b1;
                mq    = d_h[ch][u-s];
            end
        end
    endfunction

    task automatic check_ch(input int ch, input logic [7:0] got_q, input logic got_tr,
                            input int s, input logic [7:0] rv);
        bit         known;
        logic [7:0] mq;
        model(ch, cyc - 1, s, rv, known, mq);
        if (known) begin
            check($sformatf("model_q_ch%0d", ch), got_q, mq);
            check($sformatf("model_tr_ch%0d", ch), {7'b0, got_tr}, {7'b0, cap(ch, cyc - 1, 0 + s)});
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0 && cyc <= NMAX) begin
            check_ch(0, {7'b0, q0}, tr0, 2, 8'h00);
            check_ch(1, q1, tr1, 0, 8'hA5);
        end
    end

    initial begin
        rst0 = 1'b1; d0 = 1'b1;  en0 = 1'b1;
        rst1 = 1'b1; d1 = 8'h3C; en1 = 1'b1;

        // Reset with d=1, en=1 held at the pins
        repeat (2) @(negedge clk);
        check("rst_q0", {7'b0, q0}, 8'h00);
        check("rst_tr0", {7'b0, tr0}, 8'h00);
        check("rst_q1", q1, 8'hA5);
        check("rst_tr1", {7'b0, tr1}, 8'h00);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        check("bypass_q1", q1, 8'h3C);
        check("bypass_tr1", {7'b0, tr1}, 8'h01);
        check("post_rst_q0_e1", {7'b0, q0}, 8'h00);
        @(negedge clk);
        check("post_rst_q0_e2", {7'b0, q0}, 8'h00);
        @(negedge clk);
        check("post_rst_q0_e3", {7'b0, q0}, 8'h01);
        check("post_rst_tr0_e3", {7'b0, tr0}, 8'h01);

        // Hold: close en and drop d together
        repeat (4) @(negedge clk);
        en0 = 1'b0;
        d0  = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_tr0_e2", {7'b0, tr0}, 8'h01);
        check("hold_q0_e2", {7'b0, q0}, 8'h01);
        @(negedge clk);
        check("hold_tr0_e3", {7'b0, tr0}, 8'h00);
        repeat (10) @(negedge clk);
        check("hold_q0_long", {7'b0, q0}, 8'h01);

        // Transparency: d toggles every 4 cycles with en=1
        en0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d0 = k[0];
            repeat (4) @(negedge clk);
        end

        // Mid-run reset
        d0 = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_pre_q0", {7'b0, q0}, 8'h01);
        rst0 = 1'b1;
        @(negedge clk);
        check("mid_rst_q0", {7'b0, q0}, 8'h00);
        check("mid_rst_tr0", {7'b0, tr0}, 8'h00);
        rst0 = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_post_q0_e2", {7'b0, q0}, 8'h00);
        @(negedge clk);
        check("mid_post_q0_e3", {7'b0, q0}, 8'h01);

        // Test-plan loop: toggle en, then set d=i[0], random gaps
        for (int i = 0; i < 5; i++) begin
            en0 = ~en0;
            d1  = 8'($urandom());
            repeat ($urandom_range(0, 7)) @(negedge clk);
            d0  = i[0];
            en1 = ($urandom_range(0, 1) != 0);
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        // Free-running random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) d0 = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 5) == 0) en0 = ~en0;
            rst0 = ($urandom_range(0, 49) == 0);
            d1   = 8'($urandom());
            en1  = ($urandom_range(0, 2) != 0);
            rst1 = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
